// File: rtl/motion_mask_tracker.sv
// rtl/motion_mask_tracker.sv - 3x3 k-of-9 motion mask filter with plot stream and smoothed centroid
module motion_mask_tracker #(
    parameter int IMAGE_W     = 320,
    parameter int IMAGE_H     = 240,
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int ADDR_W      = 17,
    parameter int SUM_W       = 32,
    parameter int CNT_W       = 17,
    parameter int MIN_COUNT   = 400,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [3:0]        min_neighbours,
    output logic [ADDR_W-1:0] mask_rdaddress,
    input  logic              mask_data_out,
    output logic              vga_plot,
    output logic [X_W-1:0]    vga_x,
    output logic [Y_W-1:0]    vga_y,
    output logic              vga_colour,
    output logic              busy,
    output logic              centroid_valid,
    output logic              motion_detected,
    output logic [X_W-1:0]    centroid_x,
    output logic [Y_W-1:0]    centroid_y
);

    localparam int NPIX  = IMAGE_W * IMAGE_H;
    localparam int NLAST = IMAGE_W * (IMAGE_H + 1);
    localparam int Q_W   = $clog2(NLAST + 3);
    localparam int PTR_W = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
    localparam int DC_W  = (SUM_W > 1) ? $clog2(SUM_W) : 1;

    // s_q counts scan cycles; the bit returned in cycle s belongs to input index s-1
    localparam logic [Q_W-1:0]   S_NPIX   = Q_W'(NPIX);
    localparam logic [Q_W-1:0]   S_EMIT0  = Q_W'(IMAGE_W + 2);
    localparam logic [Q_W-1:0]   S_INLAST = Q_W'(NLAST + 1);
    localparam logic [Q_W-1:0]   S_EXIT   = Q_W'(NLAST + 2);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IMAGE_W - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMAGE_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMAGE_H - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(SUM_W - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_COUNT);

    typedef enum logic [2:0] {IDLE, SCAN, DIV_X, DIV_Y, SMOOTH, DONE} state_t;

    state_t            state_q, state_d;
    logic [Q_W-1:0]    s_q, s_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [X_W-1:0]    px_q, px_d;
    logic [Y_W-1:0]    py_q, py_d;
    logic [3:0]        k_q, k_d;
    logic [2:0]        c0_q, c0_d, c1_q, c1_d;
    logic              plot_q, plot_d, colour_q, colour_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic              seen_q, seen_d, motion_q, motion_d, valid_q, valid_d, busy_q, busy_d;
    logic [X_W-1:0]    avg_x_q, avg_x_d;
    logic [Y_W-1:0]    avg_y_q, avg_y_d;
    logic              lb0_q [IMAGE_W];
    logic              lb1_q [IMAGE_W];

    logic              consume, emit, in_bit, top, mid, border, div_en, motion_cond, div_last, ge;
    logic [8:0]        win;
    logic [3:0]        pop;
    logic [SUM_W-1:0]  div_num, quo_next;
    logic [CNT_W:0]    rem_sh, diff;
    logic [X_W-1:0]    raw_x;
    logic [Y_W-1:0]    raw_y;
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;

    assign consume = (state_q == SCAN) && (s_q != '0) && (s_q <= S_INLAST);
    assign emit    = (state_q == SCAN) && (s_q >= S_EMIT0) && (s_q <= S_INLAST);
    assign in_bit  = (s_q <= S_NPIX) ? mask_data_out : 1'b0;
    assign top     = lb1_q[ptr_q];
    assign mid     = lb0_q[ptr_q];
    assign win     = {c0_q, c1_q, top, mid, in_bit};
    assign border  = (px_q == '0) || (px_q == X_LAST) || (py_q == '0) || (py_q == Y_LAST);

    always_comb begin
        pop = '0;
        for (int i = 0; i < 9; i++) pop = pop + 4'(win[i]);
    end

    assign motion_cond = (count_q >= MIN_CNT);
    assign div_en      = motion_cond && (count_q != '0);
    assign div_last    = (dc_q == DC_LAST);

    // Restoring step; rem < count holds throughout, so the sign of diff decides the quotient bit
    assign div_num  = (state_q == DIV_X) ? sum_x_q : sum_y_q;
    assign rem_sh   = {rem_q, div_num[SUM_W-1]};
    assign diff     = rem_sh - {1'b0, count_q};
    assign ge       = ~diff[CNT_W];
    assign quo_next = {div_num[SUM_W-2:0], ge};

    assign raw_x = div_en ? sum_x_q[X_W-1:0] : '0;
    assign raw_y = div_en ? sum_y_q[Y_W-1:0] : '0;
    assign dx    = $signed({1'b0, raw_x}) - $signed({1'b0, avg_x_q});
    assign dy    = $signed({1'b0, raw_y}) - $signed({1'b0, avg_y_q});

    always_comb begin
        state_d  = state_q;   s_d      = s_q;      ptr_d   = ptr_q;
        px_d     = px_q;      py_d     = py_q;     k_d     = k_q;
        c0_d     = c0_q;      c1_d     = c1_q;
        plot_d   = 1'b0;      colour_d = 1'b0;     x_d     = x_q;      y_d = y_q;
        count_d  = count_q;   sum_x_d  = sum_x_q;  sum_y_d = sum_y_q;
        rem_d    = rem_q;     dc_d     = dc_q;
        seen_d   = seen_q;    avg_x_d  = avg_x_q;  avg_y_d = avg_y_q;
        motion_d = motion_q;  valid_d  = 1'b0;     busy_d  = busy_q;

        if (consume) begin
            c0_d  = c1_q;
            c1_d  = {top, mid, in_bit};
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
        if (emit) begin
            plot_d   = 1'b1;
            x_d      = px_q;
            y_d      = py_q;
            colour_d = c1_q[1] & ~border & (pop >= k_q);
            if (px_q == X_LAST) begin
                px_d = '0;
                py_d = py_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end
        if (plot_q && colour_q) begin
            count_d = (count_q == '1) ? count_q : count_q + 1'b1;
            sum_x_d = sum_x_q + SUM_W'(x_q);
            sum_y_d = sum_y_q + SUM_W'(y_q);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;   s_d = '0;     ptr_d = '0;
                    px_d    = '0;     py_d = '0;    k_d = min_neighbours;
                    count_d = '0;     sum_x_d = '0; sum_y_d = '0;
                    rem_d   = '0;     busy_d = 1'b1;
                end
            end
            SCAN: begin
                s_d = s_q + 1'b1;
                if (s_q == S_EXIT) begin
                    state_d = DIV_X;
                    dc_d    = '0;
                end
            end
            DIV_X, DIV_Y: begin
                if (div_en) begin
                    if (state_q == DIV_X) sum_x_d = quo_next;
                    else                  sum_y_d = quo_next;
                    rem_d = div_last ? '0 : (ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0]);
                end
                dc_d = dc_q + 1'b1;
                if (div_last) begin
                    dc_d    = '0;
                    state_d = (state_q == DIV_X) ? DIV_Y : SMOOTH;
                end
            end
            SMOOTH: begin
                motion_d = motion_cond;
                if (!motion_cond) begin
                    seen_d = 1'b0;
                end else if (!seen_q) begin
                    avg_x_d = raw_x;
                    avg_y_d = raw_y;
                    seen_d  = 1'b1;
                end else begin
                    avg_x_d = avg_x_q + X_W'(dx >>> ALPHA_SHIFT);
                    avg_y_d = avg_y_q + Y_W'(dy >>> ALPHA_SHIFT);
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;  s_q      <= '0;  ptr_q   <= '0;
            px_q     <= '0;    py_q     <= '0;  k_q     <= '0;
            c0_q     <= '0;    c1_q     <= '0;
            plot_q   <= 1'b0;  colour_q <= 1'b0; x_q    <= '0;  y_q <= '0;
            count_q  <= '0;    sum_x_q  <= '0;  sum_y_q <= '0;
            rem_q    <= '0;    dc_q     <= '0;
            seen_q   <= 1'b0;  avg_x_q  <= '0;  avg_y_q <= '0;
            motion_q <= 1'b0;  valid_q  <= 1'b0; busy_q <= 1'b0;
        end else begin
            state_q  <= state_d;  s_q      <= s_d;      ptr_q   <= ptr_d;
            px_q     <= px_d;     py_q     <= py_d;     k_q     <= k_d;
            c0_q     <= c0_d;     c1_q     <= c1_d;
            plot_q   <= plot_d;   colour_q <= colour_d; x_q     <= x_d;  y_q <= y_d;
            count_q  <= count_d;  sum_x_q  <= sum_x_d;  sum_y_q <= sum_y_d;
            rem_q    <= rem_d;    dc_q     <= dc_d;
            seen_q   <= seen_d;   avg_x_q  <= avg_x_d;  avg_y_q <= avg_y_d;
            motion_q <= motion_d; valid_q  <= valid_d;  busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < IMAGE_W; i++) begin
                lb0_q[i] <= 1'b0;
                lb1_q[i] <= 1'b0;
            end
        end else if (consume) begin
            lb1_q[ptr_q] <= lb0_q[ptr_q];
            lb0_q[ptr_q] <= in_bit;
        end
    end

    assign mask_rdaddress  = ((state_q == SCAN) && (s_q < S_NPIX)) ? ADDR_W'(s_q) : '0;
    assign vga_plot        = plot_q;
    assign vga_x           = x_q;
    assign vga_y           = y_q;
    assign vga_colour      = colour_q;
    assign busy            = busy_q;
    assign centroid_valid  = valid_q;
    assign motion_detected = motion_q;
    assign centroid_x      = avg_x_q;
    assign centroid_y      = avg_y_q;

endmodule

// File: tb/tb_motion_mask_tracker.sv
// tb/tb_motion_mask_tracker.sv - directed and random frames against a pixel-level reference model
module tb_motion_mask_tracker;

    localparam int W = 8, H = 6, XW = 3, YW = 3, AW = 6, SW = 16, CW = 8, MINC = 4, ASH = 1;
    localparam int NPIX    = W * H;
    localparam int T_PLOT  = W + 3;
    localparam int T_VALID = W * (H + 1) + 1 + 2 * SW + 3;
    localparam int BUDGET  = 400;

    logic          clock = 1'b0, resetn = 1'b1, start = 1'b0;
    logic [3:0]    min_neighbours = '0;
    logic [AW-1:0] mask_rdaddress;
    logic          mask_data_out;
    logic          vga_plot, vga_colour, busy, centroid_valid, motion_detected;
    logic [XW-1:0] vga_x, centroid_x;
    logic [YW-1:0] vga_y, centroid_y;

    logic mem [0:63];
    logic ram_q = 1'b0;
    int   n_tests = 0, n_fail = 0;
    int   exp_col [NPIX];
    int   m_seen = 0, m_ax = 0, m_ay = 0, m_motion = 0;

    motion_mask_tracker #(
        .IMAGE_W(W), .IMAGE_H(H), .X_W(XW), .Y_W(YW), .ADDR_W(AW),
        .SUM_W(SW), .CNT_W(CW), .MIN_COUNT(MINC), .ALPHA_SHIFT(ASH)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .min_neighbours(min_neighbours),
        .mask_rdaddress(mask_rdaddress), .mask_data_out(mask_data_out),
        .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .busy(busy), .centroid_valid(centroid_valid), .motion_detected(motion_detected),
        .centroid_x(centroid_x), .centroid_y(centroid_y)
    );

    always #5 clock = ~clock;
    always @(posedge clock) ram_q <= mem[mask_rdaddress];
    assign mask_data_out = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    task automatic fill_clear();
        for (int i = 0; i < 64; i++) mem[i] = 1'b0;
    endtask

    task automatic fill_block(input int cx, input int cy);
        fill_clear();
        for (int y = cy - 1; y <= cy + 1; y++)
            for (int x = cx - 1; x <= cx + 1; x++)
                if (x >= 0 && x < W && y >= 0 && y < H) mem[y * W + x] = 1'b1;
    endtask

    task automatic fill_random(input int dens);
        fill_clear();
        for (int i = 0; i < NPIX; i++) mem[i] = ($urandom_range(0, 99) < dens);
    endtask

    // Frame model: filter every pixel from its neighbourhood, then centroid and smoothing
    task automatic model_frame(input int k);
        int cnt, sx, sy, n, rx, ry;
        cnt = 0; sx = 0; sy = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                n = 0;
                if (x > 0 && x < W - 1 && y > 0 && y < H - 1 && mem[y * W + x])
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) n += int'(mem[(y + dy) * W + x + dx]);
                exp_col[y * W + x] = (n > 0 && n >= k) ? 1 : 0;
                if (exp_col[y * W + x] == 1) begin cnt++; sx += x; sy += y; end
            end
        if (cnt < MINC) begin
            m_motion = 0; m_seen = 0;
        end else begin
            rx = sx / cnt; ry = sy / cnt;
            if (m_seen == 0) begin m_ax = rx; m_ay = ry; end
            else begin
                m_ax = m_ax + fdiv(rx - m_ax, 1 << ASH);
                m_ay = m_ay + fdiv(ry - m_ay, 1 << ASH);
            end
            m_seen = 1; m_motion = 1;
        end
    endtask

    task automatic run_frame(input string tag, input int k, input bit stray);
        int t, first_plot, valid_at, nplots, err, extra;
        model_frame(k);
        @(negedge clock); start = 1'b1; min_neighbours = 4'(k);
        @(negedge clock); start = 1'b0;
        chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
        t = 0; first_plot = -1; valid_at = -1; nplots = 0; err = 0;
        while (t < BUDGET && valid_at < 0) begin
            if (vga_plot) begin
                if (first_plot < 0) first_plot = t;
                if (nplots >= NPIX || int'(vga_x) != nplots % W || int'(vga_y) != nplots / W
                    || int'(vga_colour) != exp_col[nplots]) err++;
                nplots++;
            end
            if (centroid_valid) valid_at = t;
            start = stray && (t == 20 || t == 40);
            @(negedge clock); t++;
        end
        start = 1'b0;
        chk({tag, ".valid_latency"}, 32'(valid_at), 32'(T_VALID));
        chk({tag, ".plot_latency"},  32'(first_plot), 32'(T_PLOT));
        chk({tag, ".plot_count"},    32'(nplots), 32'(NPIX));
        chk({tag, ".plot_errors"},   32'(err), 32'd0);
        chk({tag, ".motion"},        32'(motion_detected), 32'(m_motion));
        chk({tag, ".cx"},            32'(centroid_x), 32'(m_ax));
        chk({tag, ".cy"},            32'(centroid_y), 32'(m_ay));
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (centroid_valid || busy || vga_plot) extra++;
            @(negedge clock);
        end
        chk({tag, ".quiet_after"}, 32'(extra), 32'd0);
    endtask

    initial begin
        fill_clear();
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset.outputs", 32'({mask_rdaddress, vga_plot, vga_x, vga_y, vga_colour, busy,
                                  centroid_valid, motion_detected, centroid_x, centroid_y}), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < NPIX; i++) mem[i] = 1'b1;
        run_frame("all_ones_k9", 9, 1'b0);
        fill_clear(); mem[3 * W + 3] = 1'b1;
        run_frame("single_k1", 1, 1'b0);
        run_frame("single_k2", 2, 1'b0);
        fill_block(2, 2);
        run_frame("block22", 1, 1'b0);
        fill_block(4, 2);
        run_frame("block42", 1, 1'b0);
        for (int i = 0; i < NPIX; i++) mem[i] = 1'b1;
        run_frame("stray_start", 9, 1'b1);
        run_frame("k10_all_zero", 10, 1'b0);
        fill_block(6, 3);
        run_frame("block63_k0", 0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            fill_random($urandom_range(30, 90));
            run_frame($sformatf("rand%0d", r), $urandom_range(0, 10), 1'b0);
        end

        fill_random(80);
        @(negedge clock); start = 1'b1; min_neighbours = 4'd3;
        @(negedge clock); start = 1'b0;
        repeat (25) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("midscan_reset.outputs", 32'({mask_rdaddress, vga_plot, vga_x, vga_y, vga_colour, busy,
                                          centroid_valid, motion_detected, centroid_x, centroid_y}), 32'd0);
        m_seen = 0; m_ax = 0; m_ay = 0; m_motion = 0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        run_frame("after_reset", 3, 1'b0);
        fill_block(4, 3);
        run_frame("after_reset2", 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
